// File: rtl/lut_k_cfg.sv
// K-input look-up table with a serially loaded, double-buffered truth table.
// Config bits fill a shadow register; the active table is swapped in only when a full 2**K-bit frame is received.
module lut_k_cfg #(
  parameter int                   K       = 4,
  parameter logic [(1<<K)-1:0]    INIT    = '0,
  parameter bit                   REG_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_en,
  input  logic         cfg_sin,
  input  logic         cfg_abort,
  output logic         cfg_sout,
  output logic         cfg_busy,
  output logic         cfg_done,
  input  logic [K-1:0] sel,
  output logic         z
);

  localparam int         D    = 1 << K;
  localparam logic [K:0] LAST = (K+1)'(D - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [K:0]     cnt_q, cnt_d;
  logic [D-1:0]   shadow_q;
  logic [D-1:0]   lut_q;
  logic           done_q;
  logic           commit;
  logic           shift_ok;

  // An abort always wins over a simultaneous shift, so the bit is dropped.
  assign shift_ok = cfg_en && !cfg_abort;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (cfg_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (cfg_en) begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = (K+1)'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            commit  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + (K+1)'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      lut_q    <= INIT;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= commit;
      if (shift_ok) begin
        shadow_q <= {shadow_q[D-2:0], cfg_sin};
      end
      // The completing bit is taken straight from cfg_sin so the swap lands on the last edge.
      if (commit) begin
        lut_q <= {shadow_q[D-2:0], cfg_sin};
      end
    end
  end

  assign cfg_sout = shadow_q[D-1];
  assign cfg_busy = (state_q == SHIFT);
  assign cfg_done = done_q;

  generate
    if (REG_OUT) begin : g_reg_out
      logic z_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          z_q <= 1'b0;
        end else begin
          z_q <= lut_q[sel];
        end
      end
      assign z = z_q;
    end else begin : g_comb_out
      assign z = lut_q[sel];
    end
  endgenerate

endmodule

// File: tb/tb_lut_k_cfg.sv
// Self-checking bench for lut_k_cfg: K=3 combinational, K=4 registered, and a chain of two K=2 LUTs.
// Expected z values go through a scoreboard queue and are compared when the DUT output is sampled.
module tb_lut_k_cfg;

  typedef struct {
    logic [3:0] sel;
    logic       exp_z;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rst4;
  always #5 clk = ~clk;

  // K=3, REG_OUT=0
  logic       en3, sin3, abort3, sout3, busy3, done3, z3;
  logic [2:0] sel3;
  // K=4, REG_OUT=1, non-zero INIT
  logic       en4, sin4, abort4, sout4, busy4, done4, z4;
  logic [3:0] sel4;
  localparam logic [15:0] INIT4 = 16'h00F0;
  // Chain of two K=2 LUTs
  logic       enc, sinc, sout_c0, sout_c1, busy_c0, busy_c1, done_c0, done_c1, z_c0, z_c1;
  logic [1:0] selc;

  lut_k_cfg #(.K(3)) u_k3 (
    .clk(clk), .rst(rst), .cfg_en(en3), .cfg_sin(sin3), .cfg_abort(abort3),
    .cfg_sout(sout3), .cfg_busy(busy3), .cfg_done(done3), .sel(sel3), .z(z3));

  lut_k_cfg #(.K(4), .INIT(INIT4), .REG_OUT(1'b1)) u_k4 (
    .clk(clk), .rst(rst4), .cfg_en(en4), .cfg_sin(sin4), .cfg_abort(abort4),
    .cfg_sout(sout4), .cfg_busy(busy4), .cfg_done(done4), .sel(sel4), .z(z4));

  lut_k_cfg #(.K(2)) u_c0 (
    .clk(clk), .rst(rst), .cfg_en(enc), .cfg_sin(sinc), .cfg_abort(1'b0),
    .cfg_sout(sout_c0), .cfg_busy(busy_c0), .cfg_done(done_c0), .sel(selc), .z(z_c0));

  lut_k_cfg #(.K(2)) u_c1 (
    .clk(clk), .rst(rst), .cfg_en(enc), .cfg_sin(sout_c0), .cfg_abort(1'b0),
    .cfg_sout(sout_c1), .cfg_busy(busy_c1), .cfg_done(done_c1), .sel(selc), .z(z_c1));

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk every sel of the K=3 LUT against a table-driven vector list.
  task automatic check_k3_table(input logic [7:0] tbl, input string tag);
    vec_t vecs[8];
    for (int i = 0; i < 8; i++) begin
      vecs[i].sel   = 4'(i);
      vecs[i].exp_z = tbl[i];
    end
    for (int i = 0; i < 8; i++) begin
      sel3 = vecs[i].sel[2:0];
      exp_q.push_back(vecs[i].exp_z);
      #1;
      check($sformatf("%s_z_sel%0d", tag, i), {31'b0, z3}, {31'b0, exp_q.pop_front()});
    end
  endtask

  task automatic k3_bit(input logic b, input logic exp_busy, input logic exp_done, input string tag);
    en3  = 1'b1;
    sin3 = b;
    tick();
    check({tag, "_busy"}, {31'b0, busy3}, {31'b0, exp_busy});
    check({tag, "_done"}, {31'b0, done3}, {31'b0, exp_done});
  endtask

  // Full frame, first bit is the MSB; the new table must be visible while cfg_done is high.
  task automatic k3_frame(input logic [7:0] f, input string tag);
    for (int i = 0; i < 8; i++) begin
      k3_bit(f[7-i], (i < 7), (i == 7), $sformatf("%s_b%0d", tag, i));
    end
    en3 = 1'b0;
    check({tag, "_z_at_done"}, {31'b0, z3}, {31'b0, f[sel3]});
    check({tag, "_sout"}, {31'b0, sout3}, {31'b0, f[7]});
    tick();
    check({tag, "_done_clear"}, {31'b0, done3}, 32'd0);
  endtask

  task automatic k4_check_z(input logic [3:0] s, input logic e, input string tag);
    sel4 = s;
    exp_q.push_back(e);
    tick();
    check(tag, {31'b0, z4}, {31'b0, exp_q.pop_front()});
  endtask

  initial begin
    logic [7:0] stream;
    rst = 1'b1; rst4 = 1'b1;
    en3 = 0; sin3 = 0; abort3 = 0; sel3 = '0;
    en4 = 0; sin4 = 0; abort4 = 0; sel4 = 4'd4;
    enc = 0; sinc = 0; selc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst4 = 1'b0;

    // 1. Reset state
    check_k3_table(8'h00, "rst");
    check("rst_busy", {31'b0, busy3}, 32'd0);
    check("rst_done", {31'b0, done3}, 32'd0);
    check("rst_sout", {31'b0, sout3}, 32'd0);
    check("rst_z4_reg", {31'b0, z4}, 32'd0);
    k4_check_z(4'd4, INIT4[4], "rst_z4_init_sel4");

    // 2. Basic frame with cfg_en held high
    sel3 = 3'd7;
    k3_frame(8'b1011_0010, "f1");
    check_k3_table(8'b1011_0010, "f1");

    // 3. Old function keeps evaluating while a new frame loads
    k3_frame(8'h80, "and");
    for (int i = 0; i < 4; i++) k3_bit(1'b1, 1'b1, 1'b0, $sformatf("part_b%0d", i));
    en3 = 1'b0;
    check_k3_table(8'h80, "part");
    check("part_busy_hold", {31'b0, busy3}, 32'd1);

    // 4. Abort: clear the partial frame, load 5 bits, then abort together with cfg_en
    abort3 = 1'b1;
    tick();
    abort3 = 1'b0;
    check("abort0_busy", {31'b0, busy3}, 32'd0);
    for (int i = 0; i < 5; i++) k3_bit(1'b1, 1'b1, 1'b0, $sformatf("ab_b%0d", i));
    en3 = 1'b1; sin3 = 1'b1; abort3 = 1'b1;
    tick();
    en3 = 1'b0; abort3 = 1'b0;
    check("abort_busy", {31'b0, busy3}, 32'd0);
    check("abort_done", {31'b0, done3}, 32'd0);
    check_k3_table(8'h80, "abort");
    k3_frame(8'h6A, "post_abort");
    check_k3_table(8'h6A, "post_abort");

    // 5. K=4 registered output, gapped cfg_en loading 16'hFFFF
    sel4 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      en4 = 1'b1; sin4 = 1'b1;
      tick();
      en4 = 1'b0;
      check($sformatf("k4_b%0d_busy", i), {31'b0, busy4}, {31'b0, (i < 15)});
      check($sformatf("k4_b%0d_done", i), {31'b0, done4}, {31'b0, (i == 15)});
      if (i < 15) repeat (2) tick();
    end
    check("k4_z_at_done_old", {31'b0, z4}, {31'b0, INIT4[0]});
    tick();
    check("k4_done_clear", {31'b0, done4}, 32'd0);
    check("k4_z_after_done", {31'b0, z4}, 32'd1);
    k4_check_z(4'd3, 1'b1, "k4_z_sel3");
    k4_check_z(4'd9, 1'b1, "k4_z_sel9");
    k4_check_z(4'd15, 1'b1, "k4_z_sel15");
    for (int i = 0; i < 5; i++) begin
      en4 = 1'b1; sin4 = 1'b0;
      tick();
      en4 = 1'b0;
      tick();
    end
    check("k4_mid_busy", {31'b0, busy4}, 32'd1);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    check("k4_rst_busy", {31'b0, busy4}, 32'd0);
    check("k4_rst_done", {31'b0, done4}, 32'd0);
    check("k4_rst_sout", {31'b0, sout4}, 32'd0);
    check("k4_rst_z", {31'b0, z4}, 32'd0);
    k4_check_z(4'd4, INIT4[4], "k4_rst_init_sel4");
    k4_check_z(4'd0, INIT4[0], "k4_rst_init_sel0");
    k4_check_z(4'd9, INIT4[9], "k4_rst_init_sel9");

    // 6. Two chained K=2 LUTs, farthest frame first
    stream = 8'b0110_1000;
    for (int i = 0; i < 8; i++) begin
      enc = 1'b1; sinc = stream[7-i];
      tick();
      check($sformatf("chain_b%0d_done0", i), {31'b0, done_c0}, {31'b0, (i == 3 || i == 7)});
      check($sformatf("chain_b%0d_done1", i), {31'b0, done_c1}, {31'b0, (i == 3 || i == 7)});
    end
    enc = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [3:0] t0, t1;
      t0 = 4'b1000;
      t1 = 4'b0110;
      selc = 2'(s);
      exp_q.push_back(t0[s]);
      exp_q.push_back(t1[s]);
      #1;
      check($sformatf("chain_lut0_sel%0d", s), {31'b0, z_c0}, {31'b0, exp_q.pop_front()});
      check($sformatf("chain_lut1_sel%0d", s), {31'b0, z_c1}, {31'b0, exp_q.pop_front()});
    end
    check("chain_busy0", {31'b0, busy_c0}, 32'd0);
    check("chain_busy1", {31'b0, busy_c1}, 32'd0);
    check("chain_sout0", {31'b0, sout_c0}, 32'd1);
    check("chain_sout1", {31'b0, sout_c1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
